// File: rtl/sdram_port_arbiter.sv
// Two-port burst arbiter in front of the SDRAM controller command port.
// Capture writes win ties, bounded by a consecutive-write limit so reads cannot starve.
module sdram_port_arbiter #(
    parameter int MAX_WR_CONSEC = 2,
    parameter int TIMEOUT_CYC   = 1023
) (
    input  logic        clk_sdram,
    input  logic        reset_n,
    input  logic        wr_req,
    input  logic [21:0] wr_addr_base,
    input  logic [8:0]  wr_data_length,
    input  logic [15:0] wr_data,
    output logic        wr_data_ack,
    input  logic        rd_req,
    input  logic [21:0] rd_addr_base,
    input  logic [8:0]  rd_data_length,
    output logic [15:0] rd_data,
    output logic        rd_data_valid,
    output logic        ctl_req,
    output logic        ctl_wr,
    output logic [21:0] ctl_addr,
    output logic [8:0]  ctl_len,
    output logic [15:0] ctl_wdata,
    input  logic        ctl_wdata_ack,
    input  logic [15:0] ctl_rdata,
    input  logic        ctl_rdata_valid,
    output logic        grant_wr,
    output logic        grant_rd,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;

    localparam logic [3:0] CONSEC_LIMIT  = 4'(MAX_WR_CONSEC);
    localparam logic [9:0] TIMEOUT_LIMIT = 10'(TIMEOUT_CYC);

    state_t      state, state_next;
    logic        grant_wr_next, grant_rd_next;
    logic        ctl_req_next, ctl_wr_next, err_timeout_next;
    logic [21:0] ctl_addr_next;
    logic [8:0]  ctl_len_next;
    logic [8:0]  beat_cnt, beat_cnt_next;
    logic [9:0]  to_cnt, to_cnt_next;
    logic [3:0]  wr_consec, wr_consec_next;
    logic        beat;
    logic        pick_rd;

    // Grants are only ever high in ISSUE/BUSY, so gating by them also drops
    // any beat arriving in IDLE or GAP.
    assign wr_data_ack   = ctl_wdata_ack & grant_wr;
    assign rd_data_valid = ctl_rdata_valid & grant_rd;
    assign rd_data       = ctl_rdata;
    assign ctl_wdata     = wr_data;
    assign beat          = wr_data_ack | rd_data_valid;
    assign pick_rd       = rd_req & (~wr_req | (wr_consec >= CONSEC_LIMIT));

    always_ff @(posedge clk_sdram or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant_wr    <= 1'b0;
            grant_rd    <= 1'b0;
            ctl_req     <= 1'b0;
            ctl_wr      <= 1'b0;
            ctl_addr    <= '0;
            ctl_len     <= '0;
            err_timeout <= 1'b0;
            beat_cnt    <= '0;
            to_cnt      <= '0;
            wr_consec   <= '0;
        end else begin
            state       <= state_next;
            grant_wr    <= grant_wr_next;
            grant_rd    <= grant_rd_next;
            ctl_req     <= ctl_req_next;
            ctl_wr      <= ctl_wr_next;
            ctl_addr    <= ctl_addr_next;
            ctl_len     <= ctl_len_next;
            err_timeout <= err_timeout_next;
            beat_cnt    <= beat_cnt_next;
            to_cnt      <= to_cnt_next;
            wr_consec   <= wr_consec_next;
        end
    end

    always_comb begin
        state_next       = state;
        grant_wr_next    = grant_wr;
        grant_rd_next    = grant_rd;
        ctl_req_next     = ctl_req;
        ctl_wr_next      = ctl_wr;
        ctl_addr_next    = ctl_addr;
        ctl_len_next     = ctl_len;
        err_timeout_next = 1'b0;
        beat_cnt_next    = beat_cnt;
        to_cnt_next      = to_cnt;
        wr_consec_next   = wr_consec;

        case (state)
            IDLE: begin
                if (wr_req || rd_req) begin
                    state_next    = ISSUE;
                    ctl_req_next  = 1'b1;
                    grant_rd_next = pick_rd;
                    grant_wr_next = ~pick_rd;
                    ctl_wr_next   = ~pick_rd;
                    ctl_addr_next = pick_rd ? rd_addr_base : wr_addr_base;
                    ctl_len_next  = pick_rd ? rd_data_length : wr_data_length;
                    beat_cnt_next = '0;
                    to_cnt_next   = '0;
                    // Only writes that beat a waiting read count toward the limit.
                    if (pick_rd || !rd_req) begin
                        wr_consec_next = '0;
                    end else if (wr_consec != 4'hF) begin
                        wr_consec_next = wr_consec + 4'd1;
                    end
                end
            end

            ISSUE, BUSY: begin
                if (beat) begin
                    to_cnt_next  = '0;
                    ctl_req_next = 1'b0;
                    // Length 0 wraps to 511 here, giving a 512-beat burst.
                    if (beat_cnt == ctl_len - 9'd1) begin
                        state_next    = GAP;
                        grant_wr_next = 1'b0;
                        grant_rd_next = 1'b0;
                    end else begin
                        state_next    = BUSY;
                        beat_cnt_next = beat_cnt + 9'd1;
                    end
                end else if (to_cnt + 10'd1 == TIMEOUT_LIMIT) begin
                    state_next       = GAP;
                    ctl_req_next     = 1'b0;
                    grant_wr_next    = 1'b0;
                    grant_rd_next    = 1'b0;
                    err_timeout_next = 1'b1;
                end else begin
                    to_cnt_next = to_cnt + 10'd1;
                end
            end

            GAP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a table of arbitration vectors plus
// hand-written read, stray-beat, timeout, 512-beat and mid-burst reset sequences.
module tb_sdram_port_arbiter;

    localparam int MAX_WR_CONSEC = 2;
    localparam int TIMEOUT_CYC   = 16;

    logic        clk_sdram = 1'b0;
    logic        reset_n;
    logic        wr_req;
    logic [21:0] wr_addr_base;
    logic [8:0]  wr_data_length;
    logic [15:0] wr_data;
    logic        wr_data_ack;
    logic        rd_req;
    logic [21:0] rd_addr_base;
    logic [8:0]  rd_data_length;
    logic [15:0] rd_data;
    logic        rd_data_valid;
    logic        ctl_req;
    logic        ctl_wr;
    logic [21:0] ctl_addr;
    logic [8:0]  ctl_len;
    logic [15:0] ctl_wdata;
    logic        ctl_wdata_ack;
    logic [15:0] ctl_rdata;
    logic        ctl_rdata_valid;
    logic        grant_wr;
    logic        grant_rd;
    logic        err_timeout;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [21:0] wrAddr;
        logic [8:0]  wrLen;
        logic [21:0] rdAddr;
        logic [8:0]  rdLen;
        logic        expWr;
        logic [21:0] expAddr;
        logic [8:0]  expLen;
        int          expBeats;
    } vec_t;

    vec_t vecs[10];

    sdram_port_arbiter #(
        .MAX_WR_CONSEC(MAX_WR_CONSEC),
        .TIMEOUT_CYC  (TIMEOUT_CYC)
    ) dut (
        .clk_sdram      (clk_sdram),
        .reset_n        (reset_n),
        .wr_req         (wr_req),
        .wr_addr_base   (wr_addr_base),
        .wr_data_length (wr_data_length),
        .wr_data        (wr_data),
        .wr_data_ack    (wr_data_ack),
        .rd_req         (rd_req),
        .rd_addr_base   (rd_addr_base),
        .rd_data_length (rd_data_length),
        .rd_data        (rd_data),
        .rd_data_valid  (rd_data_valid),
        .ctl_req        (ctl_req),
        .ctl_wr         (ctl_wr),
        .ctl_addr       (ctl_addr),
        .ctl_len        (ctl_len),
        .ctl_wdata      (ctl_wdata),
        .ctl_wdata_ack  (ctl_wdata_ack),
        .ctl_rdata      (ctl_rdata),
        .ctl_rdata_valid(ctl_rdata_valid),
        .grant_wr       (grant_wr),
        .grant_rd       (grant_rd),
        .err_timeout    (err_timeout)
    );

    always #5 clk_sdram = ~clk_sdram;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        wr_req         = v.wr;
        rd_req         = v.rd;
        wr_addr_base   = v.wrAddr;
        wr_data_length = v.wrLen;
        rd_addr_base   = v.rdAddr;
        rd_data_length = v.rdLen;
    endtask

    // Returns how many extra cycles ctl_req stayed low after the call.
    task automatic waitGrant(output int lowCycles);
        lowCycles = 0;
        for (int n = 0; n < 20; n++) begin
            if (ctl_req) break;
            @(negedge clk_sdram);
            #1;
            lowCycles++;
        end
        if (!ctl_req) checkOutput("grant_wait", {31'd0, ctl_req}, 32'd1);
    endtask

    // Entered during the first ISSUE cycle; drives beats of the granted direction
    // from cycle `delay` on, optional stray beats of the other direction.
    task automatic doBurst(input logic isWr, input int delay, input bit strays, input int stopAfter,
                           output int fwd, output int strayFwd, output int reqCycles);
        bit beatOn;
        bit strayOn;
        fwd = 0;
        strayFwd = 0;
        reqCycles = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (!(grant_wr || grant_rd)) break;
            if (stopAfter != 0 && fwd == stopAfter) break;
            beatOn  = (cyc >= delay);
            strayOn = strays && (cyc % 3 == 1);
            ctl_wdata_ack   = isWr ? beatOn : strayOn;
            ctl_rdata_valid = isWr ? strayOn : beatOn;
            if (beatOn) begin
                wr_req = 1'b0;
                rd_req = 1'b0;
            end
            #1;
            if (ctl_req) reqCycles++;
            if (isWr ? wr_data_ack : rd_data_valid) fwd++;
            if (isWr ? rd_data_valid : wr_data_ack) strayFwd++;
            @(negedge clk_sdram);
            #1;
        end
        ctl_wdata_ack   = 1'b0;
        ctl_rdata_valid = 1'b0;
    endtask

    initial begin
        int lowCycles;
        int fwd;
        int strayFwd;
        int reqCycles;
        int errIdx;

        vecs[0] = '{1'b1, 1'b0, 22'h3FFFFF, 9'd4, 22'h000010, 9'd3, 1'b1, 22'h3FFFFF, 9'd4, 4};
        vecs[1] = '{1'b0, 1'b1, 22'h000020, 9'd5, 22'h000100, 9'd3, 1'b0, 22'h000100, 9'd3, 3};
        vecs[2] = '{1'b1, 1'b1, 22'h001000, 9'd4, 22'h002000, 9'd4, 1'b1, 22'h001000, 9'd4, 4};
        vecs[3] = '{1'b1, 1'b1, 22'h001004, 9'd4, 22'h002000, 9'd4, 1'b1, 22'h001004, 9'd4, 4};
        vecs[4] = '{1'b1, 1'b1, 22'h001008, 9'd4, 22'h002000, 9'd4, 1'b0, 22'h002000, 9'd4, 4};
        vecs[5] = '{1'b1, 1'b1, 22'h00100C, 9'd4, 22'h002004, 9'd4, 1'b1, 22'h00100C, 9'd4, 4};
        vecs[6] = '{1'b1, 1'b0, 22'h001010, 9'd2, 22'h002008, 9'd4, 1'b1, 22'h001010, 9'd2, 2};
        vecs[7] = '{1'b1, 1'b1, 22'h001020, 9'd4, 22'h002008, 9'd4, 1'b1, 22'h001020, 9'd4, 4};
        vecs[8] = '{1'b1, 1'b1, 22'h001024, 9'd4, 22'h002008, 9'd4, 1'b1, 22'h001024, 9'd4, 4};
        vecs[9] = '{1'b1, 1'b1, 22'h001028, 9'd4, 22'h002008, 9'd4, 1'b0, 22'h002008, 9'd4, 4};

        reset_n         = 1'b0;
        wr_req          = 1'b0;
        rd_req          = 1'b0;
        wr_addr_base    = '0;
        wr_data_length  = '0;
        wr_data         = 16'h5A5A;
        rd_addr_base    = '0;
        rd_data_length  = '0;
        ctl_wdata_ack   = 1'b0;
        ctl_rdata       = 16'h0F0F;
        ctl_rdata_valid = 1'b0;

        #3;
        checkOutput("rst_ctl_req",  {31'd0, ctl_req}, 32'd0);
        checkOutput("rst_grants",   {30'd0, grant_wr, grant_rd}, 32'd0);
        checkOutput("rst_ctl_addr", {10'd0, ctl_addr}, 32'd0);
        checkOutput("rst_ctl_len",  {23'd0, ctl_len}, 32'd0);
        checkOutput("rst_err",      {31'd0, err_timeout}, 32'd0);
        checkOutput("rst_wdata_pass", {16'd0, ctl_wdata}, 32'h5A5A);
        checkOutput("rst_rdata_pass", {16'd0, rd_data}, 32'h0F0F);

        @(negedge clk_sdram);
        reset_n = 1'b1;
        #1;

        // Arbitration table, executed back to back so the write limit carries over.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            waitGrant(lowCycles);
            if (i > 0) checkOutput($sformatf("v%0d_gap", i), lowCycles, 2);
            checkOutput($sformatf("v%0d_ctl_wr", i),   {31'd0, ctl_wr}, {31'd0, vecs[i].expWr});
            checkOutput($sformatf("v%0d_grant_wr", i), {31'd0, grant_wr}, {31'd0, vecs[i].expWr});
            checkOutput($sformatf("v%0d_grant_rd", i), {31'd0, grant_rd}, {31'd0, ~vecs[i].expWr});
            checkOutput($sformatf("v%0d_addr", i),     {10'd0, ctl_addr}, {10'd0, vecs[i].expAddr});
            checkOutput($sformatf("v%0d_len", i),      {23'd0, ctl_len}, {23'd0, vecs[i].expLen});
            doBurst(vecs[i].expWr, 1, 1'b0, 0, fwd, strayFwd, reqCycles);
            checkOutput($sformatf("v%0d_beats", i), fwd, vecs[i].expBeats);
            checkOutput($sformatf("v%0d_req_cycles", i), reqCycles, 2);
        end

        // Read burst of 256, first beat three cycles after ctl_req.
        wr_req = 1'b0;
        rd_req = 1'b1;
        rd_addr_base = 22'h000100;
        rd_data_length = 9'd256;
        waitGrant(lowCycles);
        checkOutput("rd256_addr", {10'd0, ctl_addr}, 32'h100);
        checkOutput("rd256_ctl_wr", {31'd0, ctl_wr}, 32'd0);
        checkOutput("rd256_len", {23'd0, ctl_len}, 32'd256);
        doBurst(1'b0, 3, 1'b0, 0, fwd, strayFwd, reqCycles);
        checkOutput("rd256_beats", fwd, 256);
        checkOutput("rd256_req_cycles", reqCycles, 4);
        checkOutput("rd256_gap_grants", {30'd0, grant_wr, grant_rd}, 32'd0);
        ctl_rdata = 16'hA5C3;
        #1;
        checkOutput("rdata_pass", {16'd0, rd_data}, 32'hA5C3);

        // Write burst with stray read-valid pulses.
        wr_req = 1'b1;
        wr_addr_base = 22'h00ABCD;
        wr_data_length = 9'd6;
        wr_data = 16'h1234;
        waitGrant(lowCycles);
        checkOutput("stray_wdata_pass", {16'd0, ctl_wdata}, 32'h1234);
        doBurst(1'b1, 0, 1'b1, 0, fwd, strayFwd, reqCycles);
        checkOutput("stray_beats", fwd, 6);
        checkOutput("stray_forwarded", strayFwd, 0);

        // Silent controller: abort after TIMEOUT_CYC, requester keeps asking.
        wr_req = 1'b1;
        wr_addr_base = 22'h000777;
        wr_data_length = 9'd5;
        waitGrant(lowCycles);
        wr_data_length = 9'd1;
        errIdx = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (err_timeout) begin
                errIdx = cyc;
                break;
            end
            @(negedge clk_sdram);
            #1;
        end
        checkOutput("to_err_cycle", errIdx, 16);
        checkOutput("to_ctl_req", {31'd0, ctl_req}, 32'd0);
        checkOutput("to_grant_wr", {31'd0, grant_wr}, 32'd0);
        @(negedge clk_sdram);
        #1;
        checkOutput("to_err_pulse", {31'd0, err_timeout}, 32'd0);
        waitGrant(lowCycles);
        checkOutput("to_regrant_delay", lowCycles, 1);
        checkOutput("to_regrant_len", {23'd0, ctl_len}, 32'd1);
        doBurst(1'b1, 0, 1'b0, 0, fwd, strayFwd, reqCycles);
        checkOutput("len1_beats", fwd, 1);
        checkOutput("len1_req_cycles", reqCycles, 1);

        // Length 0 means 512 beats.
        rd_req = 1'b1;
        rd_addr_base = 22'h3F0000;
        rd_data_length = 9'd0;
        waitGrant(lowCycles);
        checkOutput("len0_ctl_len", {23'd0, ctl_len}, 32'd0);
        doBurst(1'b0, 0, 1'b0, 0, fwd, strayFwd, reqCycles);
        checkOutput("len0_beats", fwd, 512);

        // Build up the write limit, then reset in the middle of a 256-beat write.
        wr_req = 1'b1;
        rd_req = 1'b1;
        wr_addr_base = 22'h000100;
        wr_data_length = 9'd1;
        waitGrant(lowCycles);
        checkOutput("pre_rst_w1", {31'd0, grant_wr}, 32'd1);
        doBurst(1'b1, 0, 1'b0, 0, fwd, strayFwd, reqCycles);
        wr_req = 1'b1;
        rd_req = 1'b1;
        wr_addr_base = 22'h2AAAAA;
        wr_data_length = 9'd256;
        waitGrant(lowCycles);
        checkOutput("pre_rst_w2", {31'd0, grant_wr}, 32'd1);
        doBurst(1'b1, 0, 1'b0, 100, fwd, strayFwd, reqCycles);
        checkOutput("pre_rst_beats", fwd, 100);
        ctl_wdata_ack = 1'b1;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_ctl_req", {31'd0, ctl_req}, 32'd0);
        checkOutput("mid_rst_grants", {30'd0, grant_wr, grant_rd}, 32'd0);
        checkOutput("mid_rst_ctl_wr", {31'd0, ctl_wr}, 32'd0);
        checkOutput("mid_rst_addr", {10'd0, ctl_addr}, 32'd0);
        checkOutput("mid_rst_len", {23'd0, ctl_len}, 32'd0);
        checkOutput("mid_rst_ack_gated", {31'd0, wr_data_ack}, 32'd0);
        @(negedge clk_sdram);
        ctl_wdata_ack = 1'b0;
        reset_n = 1'b1;
        #1;
        wr_req = 1'b1;
        rd_req = 1'b1;
        wr_addr_base = 22'h000300;
        wr_data_length = 9'd3;
        waitGrant(lowCycles);
        checkOutput("post_rst_grant_wr", {31'd0, grant_wr}, 32'd1);
        checkOutput("post_rst_addr", {10'd0, ctl_addr}, 32'h300);
        doBurst(1'b1, 0, 1'b0, 0, fwd, strayFwd, reqCycles);
        checkOutput("post_rst_beats", fwd, 3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-requester arbiter for the single SDRAM controller command port, sitting between the controller and the video write path (capture side, field to SDRAM) and read path (SDRAM to output line FIFO). It grants one burst at a time, latches the winner's address/length/direction, routes data beats and handshakes to the granted requester only, and counts beats to detect burst completion. Capture writes have priority because the input stream cannot stall. A consecutive-write limit prevents read starvation.

## Interface
Parameters:
- MAX_WR_CONSEC, 2, max consecutive write grants while rd_req is pending before the next grant is forced to read (1..15)
- TIMEOUT_CYC, 1023, cycles without a data beat in an active burst before the burst is aborted (1..1023)

Ports:
- clk_sdram  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- wr_req  in  1  write requester wants a burst; held high until its first wr_data_ack
- wr_addr_base  in  22  write burst start address; sampled at grant
- wr_data_length  in  9  write burst beat count; sampled at grant
- wr_data  in  16  write data; passed combinationally to ctl_wdata
- wr_data_ack  out  1  ctl_wdata_ack gated by active write grant
- rd_req  in  1  read requester wants a burst; held high until its first rd_data_valid
- rd_addr_base  in  22  read burst start address; sampled at grant
- rd_data_length  in  9  read burst beat count; sampled at grant
- rd_data  out  16  ctl_rdata passed through, not gated
- rd_data_valid  out  1  ctl_rdata_valid gated by active read grant
- ctl_req  out  1  burst request to controller
- ctl_wr  out  1  1 = write burst, 0 = read burst
- ctl_addr  out  22  latched burst address
- ctl_len  out  9  latched burst length
- ctl_wdata  out  16  equals wr_data
- ctl_wdata_ack  in  1  controller consumed one write beat
- ctl_rdata  in  16  read data from controller
- ctl_rdata_valid  in  1  one read beat valid
- grant_wr / grant_rd  out  1 each  registered; high in ISSUE/BUSY for that requester
- err_timeout  out  1  one-cycle pulse on burst abort

## Operation
- States: IDLE, ISSUE, BUSY, GAP.
- IDLE: if wr_req and rd_req are both high: grant read when wr_consec >= MAX_WR_CONSEC, else grant write. If only one is high, grant it. If neither is high, stay in IDLE.
  - On grant, latch addr, length, and direction into ctl_addr/ctl_len/ctl_wr; clear beat_cnt and to_cnt; go to ISSUE.
- wr_consec (4-bit, saturating): +1 on a write grant taken while rd_req is high; cleared on any read grant or on a write grant taken with rd_req low.
- ISSUE: ctl_req=1. The first beat (ctl_wdata_ack if write, ctl_rdata_valid if read) moves the state to BUSY and drops ctl_req.
- BUSY: count beats of the granted direction.
- Beat counting, ISSUE and BUSY: a beat with beat_cnt == ctl_len-1 (9-bit arithmetic) ends the burst and moves to GAP. ctl_len=0 therefore means 512 beats. A len-1 burst goes ISSUE→GAP directly.
- Beats of the non-granted direction, and any beat in IDLE/GAP, are ignored: not counted, not forwarded.
- to_cnt (10-bit): clears on each valid beat, increments otherwise in ISSUE/BUSY. Reaching TIMEOUT_CYC: ctl_req=0, err_timeout pulse, go to GAP. A requester still holding req is re-arbitrated normally.
- GAP: one cycle, all grants low, then IDLE.
- Reset (any time, including mid-burst): state IDLE; ctl_req, ctl_wr, grant_wr, grant_rd, err_timeout = 0; ctl_addr=0; ctl_len=0; wr_consec=0; beat_cnt=0; to_cnt=0. Combinational pass-throughs follow their inputs.

## Timing
- The request is seen in IDLE at edge N. At edge N+1: ctl_req=1, grant_x=1, and ctl_addr/ctl_len/ctl_wr are valid. All three are stable until the burst ends.
- First beat sampled at edge M → ctl_req=0 from M+1.
- Last beat sampled at edge L → GAP at L+1, IDLE at L+2. The earliest next ctl_req is at L+3. ctl_req is always low for ≥2 cycles between bursts.
- wr_data_ack and rd_data_valid are combinational from the controller with zero latency, gated by the registered grant.
- Simultaneous wr_req and rd_req rising in IDLE: resolved in the same cycle per the priority rule, with no extra latency.

## Test plan
- Read only: rd_req=1, rd_addr_base=0x000100, len=256; controller returns 256 beats starting 3 cycles after ctl_req → ctl_addr=0x000100, ctl_wr=0, ctl_req high until the first beat, exactly 256 rd_data_valid, GAP, then IDLE.
- Both pending continuously, len=4, MAX_WR_CONSEC=2 → grant order W,W,R,W,W,R…; ctl_req low ≥2 cycles between bursts.
- Write burst in progress with stray ctl_rdata_valid pulses → rd_data_valid stays 0; beat count is unaffected; the burst ends after exactly wr_data_length acks.
- Controller silent after ctl_req, TIMEOUT_CYC=16 → err_timeout pulses 16 cycles after ISSUE entry; ctl_req drops; re-grant occurs 2 cycles later.
- ctl_len=1 → a single beat returns to IDLE via GAP. ctl_len=0 → 512 beats are required before GAP.
- reset_n pulsed low mid-burst (beat 100 of 256) → all outputs return to reset values immediately; after release, the next request re-arbitrates from IDLE with wr_consec=0.
